// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch unit and its fetch buffer.
package ifetch_pkg;

  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP         = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } fetch_state_t;

  // Sequential successor; the 32-bit add wraps FFFF_FFFC back to 0.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous fetch buffer with push/pop/flush and registered head.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  // Head reads as zero when empty so stale slots never leak after a flush.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty && !flush;
    do_push  = push && !flush && (!full || do_pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: registered fetch PC, redirect handling, DEPTH-entry fetch buffer.
// Optional misaligned-target trap is enabled by defining IFETCH_MISALIGN_EXC_EN.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFETCH_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef IFETCH_MISALIGN_EXC_EN
  ,
  output logic        misalign_exc
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_target;
  logic         redirect_trap;
  logic         push, pop, flush;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry, head_entry;

`ifdef IFETCH_MISALIGN_EXC_EN
  assign redirect_target = redirect_pc;
  assign redirect_trap   = is_misaligned(redirect_pc[1:0]);
  assign misalign_exc    = (state_q == ST_TRAP);
`else
  // Without the trap, low target bits are dropped so fetch stays word aligned.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_trap   = 1'b0;
`endif

  assign iaddr     = pc_q;
  assign out_valid = !fifo_empty && (state_q == ST_RUN);
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

  // Redirect flushes and retargets; otherwise fetch one word whenever a slot is free.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = out_valid && out_ready;
    push_entry = '{pc: pc_q, instr: idata};

    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_target;
      state_d = redirect_trap ? ST_TRAP : ST_RUN;
    end else if ((state_q == ST_RUN) && (!fifo_full || pop)) begin
      push = 1'b1;
      pc_d = next_seq_pc(pc_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_entry)
  );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus random traffic against a queue model.
// Covers both builds; define IFETCH_MISALIGN_EXC_EN to exercise the trap path.
module tb_ifetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int          TB_DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IFETCH_MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] model_q[$];
  logic [31:0] model_pc;
  bit          model_trap;

  ifetch #(
    .RESET_PC (TB_RESET_PC),
    .DEPTH    (TB_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iaddr          (iaddr),
    .idata          (idata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef IFETCH_MISALIGN_EXC_EN
    ,
    .misalign_exc   (misalign_exc)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is a scrambled copy of its own address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  assign idata = memWord(iaddr);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%08h expected=%08h", tag, actual, expected);
    end
  endtask

  task automatic checkAll();
    bit exp_valid;
    exp_valid = (model_q.size() != 0) && !model_trap;
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      checkOutput("out_pc", out_pc, model_q[0][63:32]);
      checkOutput("out_instr", out_instr, model_q[0][31:0]);
    end
    checkOutput("iaddr", iaddr, model_pc);
`ifdef IFETCH_MISALIGN_EXC_EN
    checkOutput("misalign_exc", {31'b0, misalign_exc}, {31'b0, model_trap});
`endif
  endtask

  task automatic modelReset();
    model_q.delete();
    model_pc   = TB_RESET_PC;
    model_trap = 1'b0;
  endtask

  // One clock of the fetch rules: redirect flushes and retargets, else pop then refill.
  task automatic modelStep(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop;
    pop = (model_q.size() != 0) && !model_trap && rdy;
    if (rv) begin
      model_q.delete();
`ifdef IFETCH_MISALIGN_EXC_EN
      model_pc   = rpc;
      model_trap = (rpc % 4) != 0;
`else
      model_pc   = (rpc / 4) * 4;
      model_trap = 1'b0;
`endif
    end else begin
      if (pop) void'(model_q.pop_front());
      if (!model_trap && model_q.size() < TB_DEPTH) begin
        model_q.push_back({model_pc, memWord(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    modelStep(rv, rpc, rdy);
    @(negedge clk);
    checkAll();
  endtask

  // Called at a falling edge; checks that reset takes effect before any clock.
  task automatic pulseReset(input int cycles);
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_out_pc", out_pc, 32'h0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit          rv;
    bit          rdy;
    logic [31:0] rpc;

    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    modelReset();
    @(negedge clk);
    pulseReset(2);

    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);

    pulseReset(1);
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("full_iaddr_hold", iaddr, 32'h8);
    checkOutput("full_head_pc", out_pc, 32'h0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, 32'h100, 1'b1);
    checkOutput("redir_bubble", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir_target", out_pc, 32'h100);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, 32'h300, 1'b1);
    applyStimulus(1'b1, 32'h400, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("b2b_last_target", out_pc, 32'h400);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);

    applyStimulus(1'b1, 32'h102, 1'b1);
`ifdef IFETCH_MISALIGN_EXC_EN
    checkOutput("trap_flag", {31'b0, misalign_exc}, 32'h1);
    checkOutput("trap_iaddr", iaddr, 32'h102);
`else
    checkOutput("aligned_iaddr", iaddr, 32'h100);
`endif
    repeat (3) applyStimulus(1'b0, 32'h0, 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, 32'h200, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("resume_target", out_pc, 32'h200);

    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);

    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);
    pulseReset(2);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc[31:4] = 28'hFFF_FFFF;
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) pulseReset(1);
      applyStimulus(rv, rpc, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, fetch-buffer entries (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 iaddr  output  32  byte address to instruction memory; equals the fetch PC register.
REQ-006 idata  input  32  instruction word returned combinationally for iaddr, same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken; overrides sequential fetch.
REQ-008 redirect_pc  input  32  target byte address when redirect_valid=1.
REQ-009 out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
REQ-010 out_ready  input  1  consumer accepts the entry this cycle when out_valid=1.
REQ-011 out_instr  output  32  instruction word at buffer head.
REQ-012 out_pc  output  32  byte address of out_instr.
REQ-013 misalign_exc  output  1  target-misaligned exception flag (present only with IFETCH_MISALIGN_EXC_EN).

Function
REQ-014 Fetch PC register shall drive iaddr directly; no combinational path from any input to iaddr.
REQ-015 Each cycle with redirect_valid=0, buffer not full (or head popped same cycle) and state RUN: {pc, idata} pushed, pc <= pc+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-016 Buffer full and no pop: no push, pc held, iaddr stable.
REQ-017 Pop occurs when out_valid & out_ready; push and pop in same cycle keep occupancy unchanged.
REQ-018 Entries shall leave in program order; out_pc/out_instr stable while out_valid=1 and out_ready=0.
REQ-019 Latency: entry fetched at cycle N appears on out_* at N+1 (registered buffer, no bypass).
REQ-020 redirect_valid=1: buffer flushed (occupancy 0), pc <= redirect_pc, no push that cycle; out_valid=0 next cycle; first target instruction valid two cycles after redirect.
REQ-021 Redirect with simultaneous pop: redirect wins; popped entry counts as consumed, all others discarded.
REQ-022 Back-to-back redirects: each overrides the previous; only last target fetched.
REQ-023 States: RUN (normal fetch), TRAP (fetch halted); RUN->TRAP on misaligned redirect (with macro); TRAP->RUN on aligned redirect; TRAP with misaligned redirect stays TRAP.
REQ-024 In TRAP: no push, out_valid=0, pc holds last redirect target.

Reset
REQ-025 rst_n low: pc=RESET_PC, occupancy=0, out_valid=0, out_instr=0, out_pc=0, misalign_exc=0, state RUN, effective immediately (asynchronous).
REQ-026 Reset assertion mid-operation discards all buffered entries; first fetch at RESET_PC on first rising edge after rst_n deasserts; out_valid=1 the following cycle.

Configuration
REQ-027 Macro IFETCH_MISALIGN_EXC_EN defined: redirect_pc[1:0]!=0 enters TRAP and sets misalign_exc=1, held until aligned redirect or reset.
REQ-028 Macro undefined: misalign_exc port absent, TRAP unreachable, redirect_pc[1:0] forced to 2'b00.

Structure
REQ-029 Package ifetch_pkg holds RESET_PC default, fetch-entry typedef {pc[31:0], instr[31:0]}, state enum {RUN, TRAP}.
REQ-030 Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push/pop/flush, full/empty, async active-low reset; ifetch instantiates one.

Verification
REQ-031 Reset release, out_ready=1, memory holds sequential words -> out_pc 0,4,8,12 on consecutive cycles from cycle 1, out_valid continuous.
REQ-032 out_ready=0 for 5 cycles after reset -> buffer fills to 2, iaddr holds 32'h8, out_pc stays 0; out_ready=1 -> pc 0,4,8 delivered without gap.
REQ-033 Redirect to 32'h100 while out_pc=8 and out_ready=1 -> next cycle out_valid=0; following cycle out_pc=32'h100; entries at 12 never appear.
REQ-034 Redirect to 32'h102 with macro -> misalign_exc=1, out_valid=0, iaddr=32'h102 held; redirect to 32'h200 -> misalign_exc=0, out_pc=32'h200 two cycles later. Without macro -> fetch resumes at 32'h100.
REQ-035 RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst_n pulsed low mid-stream with full buffer -> out_valid=0 during reset, no stale entries after release, out_pc restarts at RESET_PC.
